control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit.sv | 131 +++++++++++++
 tb/tb_control_unit.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// control_unit: multi-cycle instruction sequencer driving the DataPath strobes.
//
// Ports:
//   clk          system clock, all state changes on its rising edge
//   clr          asynchronous active-low reset
//   ir[31:0]     instruction register contents, opcode in ir[31:27]
//   mem_rdy      memory handshake, only observed when CU_MEM_READY_EN is defined
//   Pout..IncPC  fetch / memory strobes
//   Gra..Write   register-select and bus strobes
//   alu_control  ALU operation select, holds its value outside T4
//   run          high while sequencing instructions
//   illegal      sticky flag, set once an undefined opcode has executed
//
// Optional feature: define CU_MEM_READY_EN to stretch the Read/Write states
// (T1, ld T6, st T7) until mem_rdy is seen high at a rising edge.
module control_unit (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        mem_rdy,
    output logic        Pout,
    output logic        MARen,
    output logic        Read,
    output logic        MDRen,
    output logic        MDROut,
    output logic        IRen,
    output logic        Pen,
    output logic        IncPC,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        Cout,
    output logic        Yen,
    output logic        ZLOen,
    output logic        ZLOout,
    output logic        Write,
    output logic [4:0]  alu_control,
    output logic        run,
    output logic        illegal
);
    typedef enum logic [3:0] {RESET_ST, T0, T1, T2, T3, T4, T5, T6, T7, HALTED} state_t;
    state_t state, next;
    logic [4:0] op, alu_q, alu_t4;
    logic is_ld, is_ldi, is_st, is_rr, is_addi, is_nop, is_halt, is_long, is_legal, stall;
    assign op       = ir[31:27];
    assign is_ld    = op == 5'b00000;
    assign is_ldi   = op == 5'b00001;
    assign is_st    = op == 5'b00010;
    assign is_rr    = op inside {5'b00011, 5'b00100, 5'b00101, 5'b00110};
    assign is_addi  = op == 5'b01100;
    assign is_nop   = op == 5'b11010;
    assign is_halt  = op == 5'b11011;
    assign is_long  = is_ld || is_ldi || is_st || is_rr || is_addi;
    assign is_legal = is_long || is_nop || is_halt;
    // register-register ops pass the opcode straight to the ALU, the rest add
    assign alu_t4      = is_rr ? op : 5'b00011;
    assign alu_control = (state == T4) ? alu_t4 : alu_q;
    assign run         = !(state == RESET_ST || state == HALTED);
`ifdef CU_MEM_READY_EN
    // memory states wait for the handshake; outputs stay up for the whole hold
    assign stall = !mem_rdy && (state == T1 || (state == T6 && is_ld) || (state == T7 && is_st));
    logic unused_ir;
    assign unused_ir = ^ir[26:0];
`else
    assign stall = 1'b0;
    logic unused_in;
    assign unused_in = ^{ir[26:0], mem_rdy};
`endif
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state   <= RESET_ST;
            alu_q   <= 5'b00000;
            illegal <= 1'b0;
        end else begin
            state <= next;
            if (state == T4) alu_q <= alu_t4;
            if (state == T3 && !is_legal) illegal <= 1'b1;
        end
    end
    always_comb begin
        next = state;
        case (state)
            RESET_ST: next = T0;
            T0:       next = T1;
            T1:       next = stall ? T1 : T2;
            T2:       next = T3;
            T3:       next = is_halt ? HALTED : (is_long ? T4 : T0);
            T4:       next = T5;
            T5:       next = (is_ld || is_st) ? T6 : T0;
            T6:       next = stall ? T6 : T7;
            T7:       next = stall ? T7 : T0;
            default:  next = HALTED;
        endcase
    end
    always_comb begin
        {Pout, MARen, Read, MDRen, MDROut, IRen, Pen, IncPC} = '0;
        {Gra, Grb, Grc, Rin, Rout, BAout, Cout, Yen, ZLOen, ZLOout, Write} = '0;
        case (state)
            T0: {Pout, MARen} = 2'b11;
            T1: {Read, MDRen, Pen, IncPC} = 4'b1111;
            T2: {MDROut, IRen} = 2'b11;
            T3: begin
                if (is_ld || is_ldi || is_st) {Grb, BAout, Yen} = 3'b111;
                if (is_rr || is_addi) {Grb, Rout, Yen} = 3'b111;
            end
            T4: begin
                ZLOen = 1'b1;
                if (is_rr) {Grc, Rout} = 2'b11;
                else Cout = 1'b1;
            end
            T5: begin
                ZLOout = 1'b1;
                if (is_ld || is_st) MARen = 1'b1;
                else {Gra, Rin} = 2'b11;
            end
            T6: begin
                MDRen = 1'b1;
                if (is_ld) Read = 1'b1;
                else {Gra, Rout} = 2'b11;
            end
            T7: begin
                if (is_ld) {MDROut, Gra, Rin} = 3'b111;
                else Write = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: randomized and directed checks of control_unit against a cycle-list model.
module tb_control_unit;
    logic clk = 1'b0, clr = 1'b1, mem_rdy = 1'b1;
    logic [31:0] ir = 32'h0;
    logic Pout, MARen, Read, MDRen, MDROut, IRen, Pen, IncPC;
    logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, Yen, ZLOen, ZLOout, Write;
    logic [4:0] alu_control;
    logic run, illegal;

    control_unit dut (
        .clk(clk), .clr(clr), .ir(ir), .mem_rdy(mem_rdy),
        .Pout(Pout), .MARen(MARen), .Read(Read), .MDRen(MDRen), .MDROut(MDROut),
        .IRen(IRen), .Pen(Pen), .IncPC(IncPC), .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout), .Yen(Yen), .ZLOen(ZLOen),
        .ZLOout(ZLOout), .Write(Write), .alu_control(alu_control), .run(run), .illegal(illegal)
    );

    always #5 clk = ~clk;

    wire [18:0] strobes = {Pout, MARen, Read, MDRen, MDROut, IRen, Pen, IncPC, Gra, Grb,
                           Grc, Rin, Rout, BAout, Cout, Yen, ZLOen, ZLOout, Write};
    localparam logic [18:0] NONE = 19'd0;
    localparam logic [18:0] POUT = 19'd1 << 18, MAREN = 19'd1 << 17, READ = 19'd1 << 16;
    localparam logic [18:0] MDREN = 19'd1 << 15, MDROUT = 19'd1 << 14, IREN = 19'd1 << 13;
    localparam logic [18:0] PEN = 19'd1 << 12, INCPC = 19'd1 << 11, GRA = 19'd1 << 10;
    localparam logic [18:0] GRB = 19'd1 << 9, GRC = 19'd1 << 8, RIN = 19'd1 << 7;
    localparam logic [18:0] ROUT = 19'd1 << 6, BAOUT = 19'd1 << 5, COUT = 19'd1 << 4;
    localparam logic [18:0] YEN = 19'd1 << 3, ZLOEN = 19'd1 << 2, ZLOOUT = 19'd1 << 1;
    localparam logic [18:0] WRITE = 19'd1;
    localparam logic [18:0] FETCH0 = POUT | MAREN;

    int total = 0, bad = 0;

    typedef struct {
        logic [18:0] s;
        logic        alu_set;
        logic [4:0]  alu;
        logic        ill;
    } step_t;
    step_t q[$];
    logic [4:0] alu_last = 5'd0;
    logic exp_ill = 1'b0;

    function automatic void push(logic [18:0] s, logic alu_set = 1'b0, logic [4:0] alu = 5'd0,
                                 logic ill = 1'b0);
        step_t e;
        e.s = s; e.alu_set = alu_set; e.alu = alu; e.ill = ill;
        q.push_back(e);
    endfunction

    // Expected strobe list for one instruction, one entry per unstalled clock.
    function automatic void model_instr(logic [4:0] op);
        push(POUT | MAREN);
        push(READ | MDREN | PEN | INCPC);
        push(MDROUT | IREN);
        case (op)
            5'd0, 5'd1, 5'd2: begin push(GRB | BAOUT | YEN); push(COUT | ZLOEN, 1'b1, 5'd3); end
            5'd3, 5'd4, 5'd5, 5'd6: begin push(GRB | ROUT | YEN); push(GRC | ROUT | ZLOEN, 1'b1, op); end
            5'd12: begin push(GRB | ROUT | YEN); push(COUT | ZLOEN, 1'b1, 5'd3); end
            5'd26: push(NONE);
            default: push(NONE, 1'b0, 5'd0, 1'b1);
        endcase
        case (op)
            5'd1, 5'd3, 5'd4, 5'd5, 5'd6, 5'd12: push(ZLOOUT | GRA | RIN);
            5'd0, 5'd2: push(ZLOOUT | MAREN);
            default: ;
        endcase
        if (op == 5'd0) begin push(READ | MDREN); push(MDROUT | GRA | RIN); end
        if (op == 5'd2) begin push(GRA | ROUT | MDREN); push(WRITE); end
    endfunction

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        clr = 1'b0;
        @(negedge clk);
        total++;
        if ({strobes, alu_control, run, illegal} !== 27'd0) begin
            bad++; $display("FAIL reset_outputs got=%h exp=0", {strobes, alu_control, run, illegal});
        end
        tick();
        total++;
        if (run !== 1'b0) begin bad++; $display("FAIL reset_held run=%b exp=0", run); end
        clr = 1'b1;
        #1;
        total++;
        if (run !== 1'b0) begin bad++; $display("FAIL reset_release_noedge run=%b exp=0", run); end
        @(negedge clk);
        total++;
        if (run !== 1'b1 || strobes !== FETCH0) begin
            bad++; $display("FAIL reset_to_t0 run=%b strobes=%h exp run=1 strobes=%h", run, strobes, FETCH0);
        end
    endtask

    task automatic test_ldi;
        logic [18:0] exp [6] = '{POUT | MAREN, READ | MDREN | PEN | INCPC, MDROUT | IREN,
                                 GRB | BAOUT | YEN, COUT | ZLOEN, ZLOOUT | GRA | RIN};
        ir = 32'h08800005;
        mem_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (strobes !== exp[i] || (i == 4 && alu_control !== 5'b00011)) begin
                bad++; $display("FAIL ldi_t%0d strobes=%h alu=%b exp strobes=%h alu=00011", i, strobes, alu_control, exp[i]);
            end
            tick();
        end
        total++;
        if (strobes !== FETCH0) begin bad++; $display("FAIL ldi_next strobes=%h exp=%h", strobes, FETCH0); end
    endtask

    task automatic test_add;
        logic [18:0] exp [6] = '{POUT | MAREN, READ | MDREN | PEN | INCPC, MDROUT | IREN,
                                 GRB | ROUT | YEN, GRC | ROUT | ZLOEN, ZLOOUT | GRA | RIN};
        ir = {5'b00011, 27'($urandom)};
        for (int i = 0; i < 6; i++) begin
            total++;
            if (strobes !== exp[i] || (i >= 4 && alu_control !== 5'b00011)) begin
                bad++; $display("FAIL add_t%0d strobes=%h alu=%b exp strobes=%h", i, strobes, alu_control, exp[i]);
            end
            tick();
        end
        total++;
        if (strobes !== FETCH0) begin bad++; $display("FAIL add_next strobes=%h exp=%h", strobes, FETCH0); end
    endtask

    task automatic test_st;
        logic [18:0] exp [9] = '{POUT | MAREN, READ | MDREN | PEN | INCPC, MDROUT | IREN,
                                 GRB | BAOUT | YEN, COUT | ZLOEN, ZLOOUT | MAREN,
                                 GRA | ROUT | MDREN, WRITE, POUT | MAREN};
        ir = {5'b00010, 27'($urandom)};
        mem_rdy = 1'b1;
        for (int i = 0; i < 9; i++) begin
            total++;
            if (strobes !== exp[i]) begin
                bad++; $display("FAIL st_t%0d strobes=%h exp=%h", i, strobes, exp[i]);
            end
            if (i < 8) tick();
        end
        alu_last = 5'd3;
    endtask

`ifdef CU_MEM_READY_EN
    task automatic test_stall;
        ir = {5'b00001, 27'($urandom)};
        mem_rdy = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (strobes !== (READ | MDREN | PEN | INCPC)) begin
                bad++; $display("FAIL stall_t1_%0d strobes=%h exp=%h", i, strobes, READ | MDREN | PEN | INCPC);
            end
            if (i == 3) mem_rdy = 1'b1;
            tick();
        end
        total++;
        if (strobes !== (MDROUT | IREN)) begin bad++; $display("FAIL stall_t2 strobes=%h exp=%h", strobes, MDROUT | IREN); end
        repeat (4) tick();
        total++;
        if (strobes !== FETCH0) begin bad++; $display("FAIL stall_next strobes=%h exp=%h", strobes, FETCH0); end
    endtask
`endif

    task automatic test_illegal;
        ir = {5'b11111, 27'($urandom)};
        total++;
        if (illegal !== 1'b0) begin bad++; $display("FAIL illegal_before got=%b exp=0", illegal); end
        repeat (4) tick();
        total++;
        if (illegal !== 1'b1 || strobes !== FETCH0) begin
            bad++; $display("FAIL illegal_after illegal=%b strobes=%h exp 1 %h", illegal, strobes, FETCH0);
        end
        exp_ill = 1'b1;
    endtask

    task automatic test_stream(input int n);
        logic [4:0] legal [9] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd12, 5'd26};
        logic [4:0] undef [5] = '{5'd7, 5'd8, 5'd13, 5'd20, 5'd31};
        for (int k = 0; k < n; k++) begin
            logic [4:0] op;
            op = ($urandom_range(0, 9) == 0) ? undef[$urandom_range(0, 4)] : legal[$urandom_range(0, 8)];
            ir = {op, 27'($urandom)};
            model_instr(op);
            while (q.size() > 0) begin
                step_t e;
                logic [4:0] ea;
                logic hold;
                e = q[0];
                ea = e.alu_set ? e.alu : alu_last;
                total++;
                if ({strobes, alu_control, run, illegal} !== {e.s, ea, 1'b1, exp_ill}) begin
                    bad++;
                    $display("FAIL stream op=%0d strobes=%h alu=%b run=%b ill=%b exp strobes=%h alu=%b run=1 ill=%b",
                             op, strobes, alu_control, run, illegal, e.s, ea, exp_ill);
                end
                mem_rdy = 1'($urandom);
`ifdef CU_MEM_READY_EN
                hold = ((e.s & (READ | WRITE)) != NONE) && !mem_rdy;
`else
                hold = 1'b0;
`endif
                if (!hold) begin
                    void'(q.pop_front());
                    if (e.alu_set) alu_last = e.alu;
                    if (e.ill) exp_ill = 1'b1;
                end
                tick();
            end
        end
        mem_rdy = 1'b1;
    endtask

    task automatic test_halt;
        ir = {5'b11011, 27'($urandom)};
        repeat (3) tick();
        total++;
        if (strobes !== NONE || run !== 1'b1) begin
            bad++; $display("FAIL halt_t3 strobes=%h run=%b exp 0 1", strobes, run);
        end
        tick();
        for (int i = 0; i < 20; i++) begin
            mem_rdy = 1'($urandom);
            ir = $urandom;
            total++;
            if (strobes !== NONE || run !== 1'b0) begin
                bad++; $display("FAIL halted_%0d strobes=%h run=%b exp 0 0", i, strobes, run);
            end
            tick();
        end
        mem_rdy = 1'b1;
    endtask

    task automatic test_reset_mid;
        clr = 1'b0;
        #1;
        total++;
        if (run !== 1'b0 || strobes !== NONE) begin bad++; $display("FAIL halt_exit_reset run=%b strobes=%h", run, strobes); end
        @(negedge clk);
        clr = 1'b1;
        tick();
        total++;
        if (illegal !== 1'b0 || strobes !== FETCH0) begin
            bad++; $display("FAIL reset_clears illegal=%b strobes=%h exp 0 %h", illegal, strobes, FETCH0);
        end
        ir = {5'b00000, 27'($urandom)};
        repeat (6) tick();
        total++;
        if (strobes !== (READ | MDREN)) begin bad++; $display("FAIL ld_t6 strobes=%h exp=%h", strobes, READ | MDREN); end
        #2 clr = 1'b0;
        #1;
        total++;
        if (Read !== 1'b0 || strobes !== NONE || run !== 1'b0 || alu_control !== 5'd0) begin
            bad++; $display("FAIL mid_reset Read=%b strobes=%h run=%b alu=%b exp all 0", Read, strobes, run, alu_control);
        end
        @(negedge clk);
        clr = 1'b1;
        tick();
        total++;
        if (strobes !== FETCH0 || run !== 1'b1) begin
            bad++; $display("FAIL mid_restart strobes=%h run=%b exp %h 1", strobes, run, FETCH0);
        end
    endtask

    initial begin
        test_reset();
        test_ldi();
        test_add();
        test_st();
`ifdef CU_MEM_READY_EN
        test_stall();
`endif
        test_illegal();
        test_stream(40);
        test_halt();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
